// File: rtl/bmcp_recv.sv
// Receive side of a multi-cycle-path CDC handshake: synchronizes the sender's
// toggle-enable, captures the held-stable data bus and returns a toggle ack.
module bmcp_recv #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             bclk,
  input  logic             brst,
  input  logic [WIDTH-1:0] adata,
  input  logic             a_en,
  input  logic             bload,
  output logic [WIDTH-1:0] bdata,
  output logic             bvalid,
  output logic             b_ack,
  output logic             b_ovf
);

  typedef enum logic [0:0] {
    S_WAIT  = 1'b0,
    S_VALID = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic               bq_en;
  logic               bq_en_d_q, bq_en_d_d;
  logic               ben;
  logic [WIDTH-1:0]   bdata_q, bdata_d;
  logic               b_ack_q, b_ack_d;
  logic               b_ovf_q, b_ovf_d;

  // Only the single-bit enable crosses through flops; adata is trusted stable
  // by the time the synchronized edge reaches the capture logic.
  genvar gi;
  generate
    for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
      if (gi == 0) begin : g_first
        assign sync_d[gi] = a_en;
      end else begin : g_rest
        assign sync_d[gi] = sync_q[gi-1];
      end
    end
  endgenerate

  assign bq_en     = sync_q[SYNC_STAGES-1];
  assign bq_en_d_d = bq_en;
  assign ben       = bq_en ^ bq_en_d_q;

  always_comb begin
    state_d = state_q;
    bdata_d = bdata_q;
    b_ack_d = b_ack_q;
    b_ovf_d = b_ovf_q;
    case (state_q)
      S_WAIT: begin
        if (ben) begin
          bdata_d = adata;
          state_d = S_VALID;
        end
      end
      S_VALID: begin
        if (bload && ben) begin
          // Consume the held word and take the new one in the same cycle.
          b_ack_d = ~b_ack_q;
          bdata_d = adata;
        end else if (bload) begin
          b_ack_d = ~b_ack_q;
          state_d = S_WAIT;
        end else if (ben) begin
          // New word arrived while the old one is unconsumed: drop it.
          b_ovf_d = 1'b1;
        end
      end
      default: state_d = S_WAIT;
    endcase
  end

  always_ff @(posedge bclk or posedge brst) begin
    if (brst) begin
      sync_q    <= '0;
      bq_en_d_q <= 1'b0;
      state_q   <= S_WAIT;
      bdata_q   <= '0;
      b_ack_q   <= 1'b0;
      b_ovf_q   <= 1'b0;
    end else begin
      sync_q    <= sync_d;
      bq_en_d_q <= bq_en_d_d;
      state_q   <= state_d;
      bdata_q   <= bdata_d;
      b_ack_q   <= b_ack_d;
      b_ovf_q   <= b_ovf_d;
    end
  end

  assign bdata  = bdata_q;
  assign bvalid = (state_q == S_VALID);
  assign b_ack  = b_ack_q;
  assign b_ovf  = b_ovf_q;

endmodule

// File: tb/tb_bmcp_recv.sv
// Directed bench for bmcp_recv: reset, capture latency, ack toggling, stall,
// overflow and asynchronous mid-operation reset.
module tb_bmcp_recv;

  logic       bclk;
  logic       brst;
  logic [7:0] adata;
  logic       a_en;
  logic       bload;
  logic [7:0] bdata;
  logic       bvalid;
  logic       b_ack;
  logic       b_ovf;

  int vec_cnt;
  int err_cnt;

  bmcp_recv #(.WIDTH(8), .SYNC_STAGES(2)) dut (
    .bclk  (bclk),
    .brst  (brst),
    .adata (adata),
    .a_en  (a_en),
    .bload (bload),
    .bdata (bdata),
    .bvalid(bvalid),
    .b_ack (b_ack),
    .b_ovf (b_ovf)
  );

  initial bclk = 1'b0;
  always #5 bclk = ~bclk;

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge bclk);
    #1;
  endtask

  task automatic do_reset();
    brst  = 1'b1;
    a_en  = 1'b0;
    bload = 1'b0;
    adata = 8'h00;
    tick();
    tick();
    brst = 1'b0;
    tick();
  endtask

  // Toggle a_en with new data; after this the word is presented (three edges).
  task automatic send_word(input logic [7:0] d);
    adata = d;
    a_en  = ~a_en;
    tick();
    tick();
    tick();
  endtask

  task automatic load_one();
    bload = 1'b1;
    tick();
    bload = 1'b0;
  endtask

  task automatic test_reset();
    brst  = 1'b1;
    bload = 1'b0;
    adata = 8'hFF;
    for (int i = 0; i < 4; i++) begin
      a_en = ~a_en;
      tick();
    end
    vec_cnt++;
    if ({bdata, bvalid, b_ack, b_ovf} !== 11'd0) begin
      err_cnt++;
      $display("FAIL reset_hold: bdata=%h bvalid=%b b_ack=%b b_ovf=%b, want all 0", bdata, bvalid, b_ack, b_ovf);
    end
    a_en = 1'b0;
    tick();
    brst = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    vec_cnt++;
    if (bvalid !== 1'b0 || b_ovf !== 1'b0) begin
      err_cnt++;
      $display("FAIL reset_release: bvalid=%b b_ovf=%b, want 0 0", bvalid, b_ovf);
    end
    $display("test_reset: bdata=%h bvalid=%b b_ack=%b b_ovf=%b", bdata, bvalid, b_ack, b_ovf);
  endtask

  task automatic test_single();
    do_reset();
    adata = 8'hA5;
    a_en  = 1'b1;
    tick();
    vec_cnt++;
    if (bvalid !== 1'b0) begin
      err_cnt++;
      $display("FAIL single_lat_e0: bvalid=%b want 0", bvalid);
    end
    tick();
    vec_cnt++;
    if (bvalid !== 1'b0) begin
      err_cnt++;
      $display("FAIL single_lat_e1: bvalid=%b want 0", bvalid);
    end
    tick();
    vec_cnt++;
    if (bvalid !== 1'b1 || bdata !== 8'hA5 || b_ack !== 1'b0) begin
      err_cnt++;
      $display("FAIL single_capture: bvalid=%b bdata=%h b_ack=%b, want 1 a5 0", bvalid, bdata, b_ack);
    end
    load_one();
    vec_cnt++;
    if (bvalid !== 1'b0 || b_ack !== 1'b1 || bdata !== 8'hA5) begin
      err_cnt++;
      $display("FAIL single_load: bvalid=%b b_ack=%b bdata=%h, want 0 1 a5", bvalid, b_ack, bdata);
    end
    // bload in WAIT must be ignored
    load_one();
    tick();
    vec_cnt++;
    if (bvalid !== 1'b0 || b_ack !== 1'b1) begin
      err_cnt++;
      $display("FAIL single_idle_load: bvalid=%b b_ack=%b, want 0 1", bvalid, b_ack);
    end
    $display("test_single: bdata=%h bvalid=%b b_ack=%b", bdata, bvalid, b_ack);
  endtask

  task automatic test_both_dirs();
    do_reset();
    send_word(8'h3C);
    vec_cnt++;
    if (bvalid !== 1'b1 || bdata !== 8'h3C) begin
      err_cnt++;
      $display("FAIL rise_capture: bvalid=%b bdata=%h, want 1 3c", bvalid, bdata);
    end
    load_one();
    vec_cnt++;
    if (b_ack !== 1'b1 || bvalid !== 1'b0) begin
      err_cnt++;
      $display("FAIL rise_ack: b_ack=%b bvalid=%b, want 1 0", b_ack, bvalid);
    end
    send_word(8'hC3);
    vec_cnt++;
    if (bvalid !== 1'b1 || bdata !== 8'hC3 || a_en !== 1'b0) begin
      err_cnt++;
      $display("FAIL fall_capture: bvalid=%b bdata=%h, want 1 c3", bvalid, bdata);
    end
    load_one();
    vec_cnt++;
    if (b_ack !== 1'b0 || bvalid !== 1'b0) begin
      err_cnt++;
      $display("FAIL fall_ack: b_ack=%b bvalid=%b, want 0 0", b_ack, bvalid);
    end
    $display("test_both_dirs: bdata=%h b_ack=%b", bdata, b_ack);
  endtask

  task automatic test_stall();
    int bad;
    do_reset();
    send_word(8'h5A);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bvalid !== 1'b1 || bdata !== 8'h5A || b_ack !== 1'b0) bad++;
    end
    vec_cnt++;
    if (bad != 0) begin
      err_cnt++;
      $display("FAIL stall_hold: %0d unstable cycles, last bvalid=%b bdata=%h b_ack=%b, want 1 5a 0", bad, bvalid, bdata, b_ack);
    end
    load_one();
    tick();
    tick();
    vec_cnt++;
    if (b_ack !== 1'b1 || bvalid !== 1'b0) begin
      err_cnt++;
      $display("FAIL stall_load: b_ack=%b bvalid=%b, want 1 0", b_ack, bvalid);
    end
    $display("test_stall: b_ack=%b bvalid=%b", b_ack, bvalid);
  endtask

  task automatic test_overflow();
    do_reset();
    send_word(8'h11);
    send_word(8'h22);
    vec_cnt++;
    if (b_ovf !== 1'b1 || bdata !== 8'h11 || bvalid !== 1'b1 || b_ack !== 1'b0) begin
      err_cnt++;
      $display("FAIL ovf_drop: b_ovf=%b bdata=%h bvalid=%b b_ack=%b, want 1 11 1 0", b_ovf, bdata, bvalid, b_ack);
    end
    // Sticky: a normal load does not clear it
    load_one();
    vec_cnt++;
    if (b_ovf !== 1'b1 || b_ack !== 1'b1) begin
      err_cnt++;
      $display("FAIL ovf_sticky: b_ovf=%b b_ack=%b, want 1 1", b_ovf, b_ack);
    end
    $display("test_overflow: b_ovf=%b bdata=%h", b_ovf, bdata);
  endtask

  task automatic test_simul_load();
    do_reset();
    send_word(8'h11);
    adata = 8'h33;
    a_en  = ~a_en;
    tick();
    tick();
    bload = 1'b1;
    tick();
    bload = 1'b0;
    vec_cnt++;
    if (b_ack !== 1'b1 || bdata !== 8'h33 || bvalid !== 1'b1 || b_ovf !== 1'b0) begin
      err_cnt++;
      $display("FAIL simul_load: b_ack=%b bdata=%h bvalid=%b b_ovf=%b, want 1 33 1 0", b_ack, bdata, bvalid, b_ovf);
    end
    $display("test_simul_load: b_ack=%b bdata=%h bvalid=%b b_ovf=%b", b_ack, bdata, bvalid, b_ovf);
  endtask

  task automatic test_async_reset();
    do_reset();
    send_word(8'h77);
    load_one();
    send_word(8'h88);
    send_word(8'h99);
    vec_cnt++;
    if (bvalid !== 1'b1 || b_ack !== 1'b1 || b_ovf !== 1'b1 || bdata !== 8'h88) begin
      err_cnt++;
      $display("FAIL async_pre: bvalid=%b b_ack=%b b_ovf=%b bdata=%h, want 1 1 1 88", bvalid, b_ack, b_ovf, bdata);
    end
    #2;
    brst = 1'b1;
    #1;
    vec_cnt++;
    if ({bdata, bvalid, b_ack, b_ovf} !== 11'd0) begin
      err_cnt++;
      $display("FAIL async_reset: bdata=%h bvalid=%b b_ack=%b b_ovf=%b, want all 0", bdata, bvalid, b_ack, b_ovf);
    end
    a_en = 1'b0;
    tick();
    brst = 1'b0;
    tick();
    $display("test_async_reset: bdata=%h bvalid=%b b_ack=%b b_ovf=%b", bdata, bvalid, b_ack, b_ovf);
  endtask

  initial begin
    vec_cnt = 0;
    err_cnt = 0;
    brst    = 1'b1;
    a_en    = 1'b0;
    bload   = 1'b0;
    adata   = 8'h00;
    test_reset();
    test_single();
    test_both_dirs();
    test_stall();
    test_overflow();
    test_simul_load();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/bmcp_recv.md
# bmcp_recv

Receive end of the multi-cycle-path (MCP) clock-domain-crossing handshake. It sits in the destination (bclk) domain, opposite the send block in the aclk domain. It synchronizes the sender's toggle-enable `a_en` and captures the held-stable multi-bit `adata` bus without synchronizing it. It presents the word to a local consumer with a valid/load handshake, then returns a toggle acknowledge `b_ack` that the sender synchronizes as its ack input.

## Interface
Parameters:
- WIDTH, 8, data word width
- SYNC_STAGES, 2, flops in the `a_en` synchronizer chain (minimum 2)

Ports:
- bclk  input  1  destination-domain clock; the only clock
- brst  input  1  asynchronous, active-high reset
- adata  input  WIDTH  sender data bus; held stable from an `a_en` toggle until the matching ack returns
- a_en  input  1  sender toggle-enable; each edge (0->1 or 1->0) marks one new word
- bload  input  1  consumer accepts the presented word; sampled only while `bvalid`=1
- bdata  output  WIDTH  captured word, registered
- bvalid  output  1  `bdata` holds an unconsumed word
- b_ack  output  1  acknowledge toggle back to the sender; flips once per consumed word
- b_ovf  output  1  sticky protocol-violation flag

## Operation
- Synchronizer: SYNC_STAGES flops clocked by bclk carry `a_en`; the last stage is `bq_en`.
- Pulse generator: one flop `bq_en_d` <= `bq_en`; `ben` = `bq_en` ^ `bq_en_d`. This gives a single-cycle pulse per `a_en` edge, in either direction.
- Receive FSM, two states:
  - WAIT (`bvalid`=0): on `ben`, `bdata` <= `adata`, go to VALID.
  - VALID (`bvalid`=1), `bload`=1 and `ben`=0: toggle `b_ack`, go to WAIT. `bdata` keeps its last value.
  - VALID, `bload`=0 and `ben`=0: hold.
  - VALID, `bload`=1 and `ben`=1: toggle `b_ack`, capture the new `adata`, stay in VALID. No overflow.
  - VALID, `bload`=0 and `ben`=1: protocol violation. Set `b_ovf`. Drop the new word, so `bdata` is unchanged. Stay in VALID. No `b_ack` toggle.
- `bload` while in WAIT is ignored.
- `b_ovf` clears only on reset.
- `adata` is sampled only on the `ben` cycle. It is never passed through the synchronizer.
- Reset values: every synchronizer flop, `bq_en_d`, `b_ack`, `bvalid`, `b_ovf` and `bdata` are 0; FSM is in WAIT.
- Reset mid-operation clears all state immediately. Any presented word is lost, and no ack is issued for it.
- Both domains are reset together, and `a_en` is 0 at reset release. If `a_en` is 1 at release, one spurious capture results; this is outside the protocol.

## Timing
- An `a_en` edge that meets setup at bclk edge 0 gives:
  - `bq_en` changes at edge SYNC_STAGES-1.
  - `ben` is high for the cycle following that edge.
  - `bdata` and `bvalid` update at edge SYNC_STAGES.
  - With the default, `bvalid` rises 2 bclk edges after the sampling edge, so it is visible 3 edges after the `a_en` toggle in the worst case.
- Metastability adds at most one extra cycle of latency.
- `bload`=1 at edge k with `bvalid`=1: `bvalid` falls and `b_ack` toggles at edge k. Throughput is one word per full round trip.
- Every output is a flop output. No combinational path from any input to any output.
- `ben` lasts exactly one cycle per `a_en` edge. Back-to-back `a_en` toggles faster than the sender's ack round trip violate the protocol and are reported through `b_ovf` only when the FSM is in VALID.

## Test plan
- Reset: hold `brst`=1 with `a_en`=1 toggling. Required: `bdata`=0, `bvalid`=0, `b_ack`=0, `b_ovf`=0. After release with `a_en`=0, no `bvalid` assertion.
- Single word: `adata`=0xA5, toggle `a_en` 0->1. Required: `bvalid`=1 and `bdata`=0xA5 at the SYNC_STAGES-th bclk edge after sampling. Then pulse `bload` for one cycle. Required: `bvalid`=0 and `b_ack` 0->1 on that same edge.
- Both toggle directions: send 0x3C (`a_en` 0->1) then 0xC3 (`a_en` 1->0), each loaded. Required: two captures and `b_ack` sequence 1, 0.
- Consumer stall: hold `bload`=0 for 20 cycles after `bvalid`. Required: `bvalid` and `bdata` stable, `b_ack` unchanged. Load on cycle 21 gives one ack toggle.
- Overflow: with 0x11 unconsumed, toggle `a_en` carrying 0x22. Required: `b_ovf`=1, `bdata` stays 0x11, no ack. Simultaneous `bload`+`ben` with 0x33 instead gives an ack toggle, `bdata`=0x33, `bvalid`=1 and `b_ovf` unchanged.
- Mid-operation reset: assert `brst` while `bvalid`=1. Required: all outputs 0 asynchronously, before the next bclk edge.
